beep_scheduler: RTL

//  Arbitrates the single beeper/audio path between three requesters: alarm, hourly chime, key click.

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/beep_pattern_gen.sv | 90 +++++++++
 rtl/beep_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types, tone codes and helpers for the beeper scheduler.
package clock_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StClick,
    StChimeOn,
    StChimeOff,
    StAlarmOn,
    StAlarmOff
  } state_e;

  // tone_sel encodings seen by the audio player.
  localparam logic [1:0] TONE_NONE  = 2'd0;
  localparam logic [1:0] TONE_CLICK = 2'd1;
  localparam logic [1:0] TONE_CHIME = 2'd2;
  localparam logic [1:0] TONE_ALARM = 2'd3;

  // Widths of the pattern generator's cycle counters and pulse counter.
  localparam int unsigned CycW   = 32;
  localparam int unsigned PulseW = 4;

  // Pulse count of zero means "repeat until stopped".
  localparam logic [PulseW-1:0] PULSES_INF = '0;

  // Hour of day 0..23 mapped to 1..12 chime strokes (midnight/noon give 12).
  function automatic logic [PulseW-1:0] hour12(input logic [5:0] h);
    logic [PulseW-1:0] m;
    m = PulseW'(h % 6'd12);
    return (m == '0) ? PulseW'(12) : m;
  endfunction

  // Tone class shown for a given state; OFF phases keep their class.
  function automatic logic [1:0] tone_of(input state_e s);
    logic [1:0] t;
    unique case (s)
      StClick:                t = TONE_CLICK;
      StChimeOn, StChimeOff:  t = TONE_CHIME;
      StAlarmOn, StAlarmOff:  t = TONE_ALARM;
      default:                t = TONE_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// Pulse-train generator: on load it latches on/off lengths and a pulse count (0 = endless)
// and produces the gate level. It also exposes its next-state so the owner FSM can track it.
module beep_pattern_gen
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              stop_i,
  input  logic [CycW-1:0]   on_cyc_i,
  input  logic [CycW-1:0]   off_cyc_i,
  input  logic [PulseW-1:0] count_i,
  output logic              level_o,
  output logic              active_nxt_o,
  output logic              level_nxt_o
);

  logic              active_q, active_d;
  logic              on_q, on_d;
  logic              inf_q, inf_d;
  logic [CycW-1:0]   cnt_q, cnt_d;
  logic [CycW-1:0]   on_cyc_q, on_cyc_d;
  logic [CycW-1:0]   off_cyc_q, off_cyc_d;
  logic [PulseW-1:0] rem_q, rem_d;

  // Next-state: load wins over stop; otherwise walk the on/off phases of the current pulse.
  always_comb begin
    active_d  = active_q;
    on_d      = on_q;
    inf_d     = inf_q;
    cnt_d     = cnt_q;
    on_cyc_d  = on_cyc_q;
    off_cyc_d = off_cyc_q;
    rem_d     = rem_q;
    if (load_i) begin
      active_d  = 1'b1;
      on_d      = 1'b1;
      cnt_d     = on_cyc_i - CycW'(1);
      on_cyc_d  = on_cyc_i;
      off_cyc_d = off_cyc_i;
      rem_d     = count_i;
      inf_d     = (count_i == PULSES_INF);
    end else if (stop_i) begin
      active_d = 1'b0;
      on_d     = 1'b0;
      cnt_d    = '0;
      rem_d    = '0;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CycW'(1);
      end else if (on_q && (off_cyc_q != '0)) begin
        on_d  = 1'b0;
        cnt_d = off_cyc_q - CycW'(1);
      end else if (inf_q || (rem_q > PulseW'(1))) begin
        on_d  = 1'b1;
        cnt_d = on_cyc_q - CycW'(1);
        if (!inf_q) rem_d = rem_q - PulseW'(1);
      end else begin
        active_d = 1'b0;
        on_d     = 1'b0;
      end
    end
  end

  // Pattern state registers; on_q doubles as the registered gate output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= 1'b0;
      on_q      <= 1'b0;
      inf_q     <= 1'b0;
      cnt_q     <= '0;
      on_cyc_q  <= '0;
      off_cyc_q <= '0;
      rem_q     <= '0;
    end else begin
      active_q  <= active_d;
      on_q      <= on_d;
      inf_q     <= inf_d;
      cnt_q     <= cnt_d;
      on_cyc_q  <= on_cyc_d;
      off_cyc_q <= off_cyc_d;
      rem_q     <= rem_d;
    end
  end

  assign level_o      = on_q;
  assign active_nxt_o = active_d;
  assign level_nxt_o  = on_d;

endmodule

// File: rtl/beep_scheduler.sv
// Beeper arbiter: alarm > chime > key click. Owns the timeout and snooze counters and
// drives the pattern generator. Define NIGHT_MUTE_EN to mask chimes from 22:00 to 06:59.
module beep_scheduler
  import clock_pkg::*;
#(
  parameter int unsigned CLICK_CYC       = 2_000_000,
  parameter int unsigned CHIME_ON_CYC    = 20_000_000,
  parameter int unsigned CHIME_OFF_CYC   = 30_000_000,
  parameter int unsigned ALARM_ON_CYC    = 25_000_000,
  parameter int unsigned ALARM_OFF_CYC   = 25_000_000,
  parameter int unsigned ALARM_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S        = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       set_mod,
  input  logic       alarm_en,
  input  logic [5:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       key_press,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       beep_en,
  output logic [1:0] tone_sel,
  output logic       alarm_ringing,
  output logic       snooze_pending
);

  state_e            state_q, state_d, follow_st;
  logic [1:0]        tone_sel_q;
  logic              ringing_q;
  logic              snz_pend_q, snz_pend_d;
  logic [31:0]       snz_cnt_q, snz_cnt_d;
  logic [31:0]       timeout_q, timeout_d;
  logic              alarm_match, chime_req, night_mute, snooze_fire, alarm_req;
  logic              gen_load, gen_stop, gen_level, gen_active_nxt, gen_level_nxt;
  logic [CycW-1:0]   ld_on, ld_off;
  logic [PulseW-1:0] ld_cnt;

`ifdef NIGHT_MUTE_EN
  assign night_mute = (hours >= 6'd22) || (hours <= 6'd6);
`else
  assign night_mute = 1'b0;
`endif

  // Time-of-day triggers, only meaningful in the second-strobe cycle.
  always_comb begin
    alarm_match = sec_tick && alarm_en && (hours == alarm_hours) &&
                  (minutes == alarm_minutes) && (seconds == 6'd0);
    chime_req   = sec_tick && !set_mod && (minutes == 6'd0) && (seconds == 6'd0) && !night_mute;
  end

  // State the FSM takes when nothing intervenes: mirror the generator's next phase.
  always_comb begin
    follow_st = StIdle;
    unique case (state_q)
      StClick:               follow_st = gen_active_nxt ? StClick : StIdle;
      StChimeOn, StChimeOff: follow_st = !gen_active_nxt ? StIdle :
                                         (gen_level_nxt ? StChimeOn : StChimeOff);
      StAlarmOn, StAlarmOff: follow_st = gen_level_nxt ? StAlarmOn : StAlarmOff;
      default:               follow_st = StIdle;
    endcase
  end

  // Arbitration, snooze countdown and alarm timeout.
  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    snz_pend_d  = snz_pend_q;
    snz_cnt_d   = snz_cnt_q;
    gen_load    = 1'b0;
    gen_stop    = 1'b0;
    ld_on       = '0;
    ld_off      = '0;
    ld_cnt      = PULSES_INF;
    snooze_fire = 1'b0;

    // Dismiss beats an expiring snooze in the same cycle.
    if (snz_pend_q) begin
      if (dismiss || !alarm_en) begin
        snz_pend_d = 1'b0;
      end else if (sec_tick) begin
        if (snz_cnt_q + 32'd1 >= SNOOZE_S) begin
          snz_pend_d  = 1'b0;
          snooze_fire = 1'b1;
        end else begin
          snz_cnt_d = snz_cnt_q + 32'd1;
        end
      end
    end
    alarm_req = alarm_match || snooze_fire;

    unique case (state_q)
      StAlarmOn, StAlarmOff: begin
        if (dismiss || !alarm_en) begin
          state_d  = StIdle;
          gen_stop = 1'b1;
        end else if (snooze) begin
          state_d    = StIdle;
          gen_stop   = 1'b1;
          snz_pend_d = 1'b1;
          snz_cnt_d  = '0;
        end else if (sec_tick && (timeout_q + 32'd1 >= ALARM_TIMEOUT_S)) begin
          state_d  = StIdle;
          gen_stop = 1'b1;
        end else begin
          state_d = follow_st;
          if (sec_tick) timeout_d = timeout_q + 32'd1;
        end
      end
      default: begin
        if (alarm_req) begin
          state_d    = StAlarmOn;
          gen_load   = 1'b1;
          ld_on      = CycW'(ALARM_ON_CYC);
          ld_off     = CycW'(ALARM_OFF_CYC);
          ld_cnt     = PULSES_INF;
          timeout_d  = '0;
          snz_pend_d = 1'b0;
        end else if (chime_req && ((state_q == StIdle) || (state_q == StClick))) begin
          state_d  = StChimeOn;
          gen_load = 1'b1;
          ld_on    = CycW'(CHIME_ON_CYC);
          ld_off   = CycW'(CHIME_OFF_CYC);
          ld_cnt   = hour12(hours);
        end else if (key_press && (state_q == StIdle)) begin
          state_d  = StClick;
          gen_load = 1'b1;
          ld_on    = CycW'(CLICK_CYC);
          ld_off   = '0;
          ld_cnt   = PulseW'(1);
        end else begin
          state_d = follow_st;
        end
      end
    endcase
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tone_sel_q <= TONE_NONE;
      ringing_q  <= 1'b0;
      snz_pend_q <= 1'b0;
      snz_cnt_q  <= '0;
      timeout_q  <= '0;
    end else begin
      state_q    <= state_d;
      tone_sel_q <= tone_of(state_d);
      ringing_q  <= (state_d == StAlarmOn) || (state_d == StAlarmOff);
      snz_pend_q <= snz_pend_d;
      snz_cnt_q  <= snz_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  beep_pattern_gen u_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (gen_load),
    .stop_i       (gen_stop),
    .on_cyc_i     (ld_on),
    .off_cyc_i    (ld_off),
    .count_i      (ld_cnt),
    .level_o      (gen_level),
    .active_nxt_o (gen_active_nxt),
    .level_nxt_o  (gen_level_nxt)
  );

  assign beep_en        = gen_level;
  assign tone_sel       = tone_sel_q;
  assign alarm_ringing  = ringing_q;
  assign snooze_pending = snz_pend_q;

endmodule
